// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: runs one parsed command packet through the shared ALU.
// Payload bytes are assembled into little-endian 32-bit words and folded into an
// accumulator through the ALU start/done handshake. The 32-bit result is then
// sent LSB-first on the TX byte stream. ECHO payloads are forwarded straight to TX.
module alu_op_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [7:0]       cmd_opcode_i,
    input  logic [CNT_W-1:0] cmd_len_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_valid_i,
    output logic             rx_ready_o,
    output logic             alu_start_o,
    output logic [7:0]       alu_op_o,
    output logic [31:0]      alu_a_o,
    output logic [31:0]      alu_b_o,
    input  logic             alu_done_i,
    input  logic [31:0]      alu_result_i,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic             busy_o,
    output logic             err_o
);

    localparam logic [7:0] OP_ECHO = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_MUL  = 8'h02;
    localparam logic [7:0] OP_DIV  = 8'h03;

    typedef enum logic [2:0] {
        StIdle, StEchoFwd, StLoad, StAluReq, StAluWait, StDrain, StSend
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       opcode_q;
    logic [CNT_W-1:0] rem_q;      // payload bytes still to consume
    logic [CNT_W-1:0] words_q;    // whole words still to load
    logic [1:0]       tail_q;
    logic             first_q;    // next word seeds the accumulator
    logic             pending_q;  // a valid result waits behind DRAIN
    logic [31:0]      acc_q;
    logic [31:0]      operand_q;
    logic [23:0]      shift_q;    // first three bytes of the word being assembled
    logic [1:0]       byte_idx_q;
    logic [1:0]       tx_idx_q;
    logic [31:0]      timer_q;
    logic             err_q;

    logic             cmd_fire, rx_fire, tx_fire, word_done, timeout, known_op;
    logic [CNT_W-1:0] cmd_words;
    logic [31:0]      full_word;
    state_e           finish_st;

    assign cmd_fire  = cmd_valid_i & cmd_ready_o;
    assign rx_fire   = rx_valid_i & rx_ready_o;
    assign tx_fire   = tx_valid_o & tx_ready_i;
    assign cmd_words = cmd_len_i >> 2;
    assign known_op  = (cmd_opcode_i == OP_ADD) || (cmd_opcode_i == OP_MUL) ||
                       (cmd_opcode_i == OP_DIV);
    assign word_done = (state_q == StLoad) && rx_fire && (byte_idx_q == 2'd3);
    assign full_word = {rx_data_i, shift_q};
    assign timeout   = (state_q == StAluWait) && !alu_done_i &&
                       (timer_q == 32'(TIMEOUT_CYCLES - 1));
    // After the last word, trailing bytes must be swallowed before the result goes out
    assign finish_st = (tail_q != 2'd0) ? StDrain : StSend;

    assign alu_op_o = opcode_q;
    assign alu_a_o  = acc_q;
    assign alu_b_o  = operand_q;
    assign busy_o   = (state_q != StIdle);
    assign err_o    = err_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    if (cmd_opcode_i == OP_ECHO) begin
                        state_d = (cmd_len_i == '0) ? StIdle : StEchoFwd;
                    end else if (known_op) begin
                        if (cmd_words == '0) begin
                            state_d = (cmd_len_i[1:0] != 2'd0) ? StDrain : StIdle;
                        end else begin
                            state_d = StLoad;
                        end
                    end else begin
                        state_d = (cmd_len_i == '0) ? StIdle : StDrain;
                    end
                end
            end
            StEchoFwd: if (rx_fire && rem_q == CNT_W'(1)) state_d = StIdle;
            StLoad: begin
                if (word_done) begin
                    if (!first_q)                    state_d = StAluReq;
                    else if (words_q == CNT_W'(1))   state_d = finish_st;
                end
            end
            StAluReq: state_d = StAluWait;
            StAluWait: begin
                if (alu_done_i)   state_d = (words_q == '0) ? finish_st : StLoad;
                else if (timeout) state_d = StDrain;
            end
            StDrain: begin
                if (rem_q == '0 || (rx_fire && rem_q == CNT_W'(1))) begin
                    state_d = pending_q ? StSend : StIdle;
                end
            end
            StSend: if (tx_fire && tx_idx_q == 2'd3) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake and data outputs decoded from the current state
    always_comb begin
        cmd_ready_o = 1'b0;
        rx_ready_o  = 1'b0;
        tx_valid_o  = 1'b0;
        tx_data_o   = 8'h00;
        alu_start_o = 1'b0;
        case (state_q)
            StIdle:    cmd_ready_o = 1'b1;
            StEchoFwd: begin
                tx_data_o  = rx_data_i;
                tx_valid_o = rx_valid_i;
                rx_ready_o = tx_ready_i;
            end
            StLoad:    rx_ready_o = 1'b1;
            StAluReq:  alu_start_o = 1'b1;
            StDrain:   rx_ready_o = (rem_q != '0);
            StSend: begin
                tx_valid_o = 1'b1;
                tx_data_o  = acc_q[{tx_idx_q, 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    // Datapath: counters, word assembly, accumulator and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q   <= 8'h00;
            rem_q      <= '0;
            words_q    <= '0;
            tail_q     <= 2'd0;
            first_q    <= 1'b0;
            pending_q  <= 1'b0;
            acc_q      <= 32'h0;
            operand_q  <= 32'h0;
            shift_q    <= 24'h0;
            byte_idx_q <= 2'd0;
            tx_idx_q   <= 2'd0;
            timer_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cmd_fire) begin
                        opcode_q   <= cmd_opcode_i;
                        rem_q      <= cmd_len_i;
                        words_q    <= cmd_words;
                        tail_q     <= cmd_len_i[1:0];
                        first_q    <= 1'b1;
                        pending_q  <= 1'b0;
                        byte_idx_q <= 2'd0;
                        tx_idx_q   <= 2'd0;
                        err_q      <= !(known_op || cmd_opcode_i == OP_ECHO);
                    end
                end
                StEchoFwd: if (rx_fire) rem_q <= rem_q - CNT_W'(1);
                StLoad: begin
                    if (rx_fire) begin
                        rem_q      <= rem_q - CNT_W'(1);
                        byte_idx_q <= byte_idx_q + 2'd1;
                        shift_q    <= {rx_data_i, shift_q[23:8]};
                    end
                    if (word_done) begin
                        words_q <= words_q - CNT_W'(1);
                        if (first_q) begin
                            acc_q     <= full_word;
                            first_q   <= 1'b0;
                            pending_q <= (words_q == CNT_W'(1));
                        end else begin
                            operand_q <= full_word;
                        end
                    end
                end
                StAluReq: timer_q <= 32'h0;
                StAluWait: begin
                    timer_q <= timer_q + 32'd1;
                    if (alu_done_i) begin
                        acc_q     <= alu_result_i;
                        pending_q <= (words_q == '0);
                    end else if (timeout) begin
                        err_q     <= 1'b1;
                        pending_q <= 1'b0;
                    end
                end
                StDrain: if (rx_fire) rem_q <= rem_q - CNT_W'(1);
                StSend:  if (tx_fire) tx_idx_q <= tx_idx_q + 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small ALU model and TX/err monitors.
module tb_alu_op_sequencer;

    localparam int unsigned TO = 16;
    localparam logic [7:0] OP_ECHO = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_MUL  = 8'h02;
    localparam logic [7:0] OP_DIV  = 8'h03;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode = 8'h00;
    logic [15:0] cmd_len = 16'h0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        alu_start;
    logic [7:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic        alu_done;
    logic [31:0] alu_result;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy, err;

    // ALU model (latency 3) plus a forced done path for the reset test
    logic        alu_en = 1'b1;
    logic        alu_done_m = 1'b0;
    logic        alu_done_f = 1'b0;
    logic [31:0] alu_res_m = 32'h0;
    logic [31:0] alu_res_f = 32'h0;
    logic [31:0] alu_pend = 32'h0;
    int          alu_cnt = 0;

    logic tx_toggle = 1'b0;
    logic tx_tog = 1'b0;
    logic tx_base = 1'b1;

    assign alu_done   = alu_done_m | alu_done_f;
    assign alu_result = alu_done_f ? alu_res_f : alu_res_m;
    assign tx_ready   = tx_toggle ? tx_tog : tx_base;

    alu_op_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_opcode_i(cmd_opcode),
        .cmd_len_i   (cmd_len),
        .rx_data_i   (rx_data),
        .rx_valid_i  (rx_valid),
        .rx_ready_o  (rx_ready),
        .alu_start_o (alu_start),
        .alu_op_o    (alu_op),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_done_i  (alu_done),
        .alu_result_i(alu_result),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid),
        .tx_ready_i  (tx_ready),
        .busy_o      (busy),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1 tx_tog = ~tx_tog;
    end

    always @(negedge clk) begin
        alu_done_m = 1'b0;
        if (alu_cnt != 0) begin
            alu_cnt = alu_cnt - 1;
            if (alu_cnt == 0) begin
                alu_done_m = alu_en;
                alu_res_m  = alu_pend;
            end
        end
        if (alu_start) begin
            alu_cnt = 3;
            case (alu_op)
                OP_ADD:  alu_pend = alu_a + alu_b;
                OP_MUL:  alu_pend = alu_a * alu_b;
                OP_DIV:  alu_pend = (alu_b == 32'h0) ? 32'hFFFF_FFFF : alu_a / alu_b;
                default: alu_pend = alu_a;
            endcase
        end
    end

    logic [7:0] tx_log[$];
    int n_start = 0, n_err = 0, start_cyc = 0, err_cyc = 0;
    always @(negedge clk) begin
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
        if (alu_start) begin n_start = n_start + 1; start_cyc = cyc; end
        if (err) begin n_err = n_err + 1; err_cyc = cyc; end
    end

    int n_pass = 0, n_total = 0;
    logic [7:0] rx_q[$];
    int b_tx, b_start, b_err;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic mark();
        b_tx = tx_log.size();
        b_start = n_start;
        b_err = n_err;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [15:0] len);
        logic ok;
        ok = 1'b0;
        cmd_opcode = op;
        cmd_len = len;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        step();
        cmd_valid = 1'b0;
        check("cmd_accept", 32'(ok), 32'd1);
    endtask

    task automatic send_bytes();
        logic ok;
        ok = 1'b1;
        while (rx_q.size() != 0) begin
            logic got;
            got = 1'b0;
            rx_data = rx_q.pop_front();
            rx_valid = 1'b1;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (rx_ready) begin got = 1'b1; break; end
            end
            if (!got) ok = 1'b0;
            step();
        end
        rx_valid = 1'b0;
        check("rx_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic check_tx(input string tag, input int n, input logic [31:0] word);
        check({tag, "_count"}, 32'(tx_log.size() - b_tx), 32'(n));
        for (int i = 0; i < n; i++) begin
            logic [7:0] got;
            got = (b_tx + i < tx_log.size()) ? tx_log[b_tx + i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(word[8*i +: 8]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_alu_start"}, 32'(alu_start), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_alu_a"}, alu_a, 32'd0);
        check({tag, "_alu_b"}, alu_b, 32'd0);
        check({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // ADD of three words: 5 + 7 + 0xFFFFFFFF wraps to 0x0B
        mark();
        send_cmd(OP_ADD, 16'd12);
        rx_q = {8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00,
                8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_bytes();
        wait_idle("add12_idle");
        check_tx("add12_tx", 4, 32'h0000_000B);
        check("add12_starts", 32'(n_start - b_start), 32'd2);
        check("add12_err", 32'(n_err - b_err), 32'd0);
        check("add12_cmd_ready", 32'(cmd_ready), 32'd1);

        // ECHO with TX ready toggling every cycle
        step();
        mark();
        tx_toggle = 1'b1;
        send_cmd(OP_ECHO, 16'd3);
        rx_q = {8'h41, 8'h42, 8'h43};
        send_bytes();
        wait_idle("echo_idle");
        tx_toggle = 1'b0;
        check_tx("echo_tx", 3, 32'h0043_4241);
        check("echo_starts", 32'(n_start - b_start), 32'd0);

        // MUL with a single word: no ALU use, word sent back as-is
        step();
        mark();
        send_cmd(OP_MUL, 16'd4);
        rx_q = {8'h78, 8'h56, 8'h34, 8'h12};
        send_bytes();
        wait_idle("mul4_idle");
        check_tx("mul4_tx", 4, 32'h1234_5678);
        check("mul4_starts", 32'(n_start - b_start), 32'd0);

        // ADD len=6: result only after the two tail bytes are drained
        step();
        mark();
        send_cmd(OP_ADD, 16'd6);
        rx_q = {8'h09, 8'h00, 8'h00, 8'h00};
        send_bytes();
        step();
        step();
        step();
        check("add6_no_early_tx", 32'(tx_log.size() - b_tx), 32'd0);
        check("add6_draining", 32'(rx_ready), 32'd1);
        rx_q = {8'hAA, 8'hBB};
        send_bytes();
        wait_idle("add6_idle");
        check_tx("add6_tx", 4, 32'h0000_0009);

        // ADD len=2: drained, nothing sent
        step();
        mark();
        send_cmd(OP_ADD, 16'd2);
        rx_q = {8'h01, 8'h02};
        send_bytes();
        wait_idle("add2_idle");
        check_tx("add2_tx", 0, 32'h0);
        check("add2_starts", 32'(n_start - b_start), 32'd0);
        check("add2_err", 32'(n_err - b_err), 32'd0);

        // Unknown opcode: one err pulse, payload drained, no TX
        step();
        mark();
        send_cmd(8'h55, 16'd4);
        rx_q = {8'h01, 8'h02, 8'h03, 8'h04};
        send_bytes();
        wait_idle("badop_idle");
        check("badop_err", 32'(n_err - b_err), 32'd1);
        check_tx("badop_tx", 0, 32'h0);
        check("badop_starts", 32'(n_start - b_start), 32'd0);

        // ALU timeout: err lands 1 + TO cycles after the start pulse
        step();
        mark();
        alu_en = 1'b0;
        send_cmd(OP_ADD, 16'd8);
        rx_q = {8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        send_bytes();
        wait_idle("timeout_idle");
        check("timeout_err", 32'(n_err - b_err), 32'd1);
        check("timeout_starts", 32'(n_start - b_start), 32'd1);
        check("timeout_latency", 32'(err_cyc - start_cyc), 32'(TO + 1));
        check_tx("timeout_tx", 0, 32'h0);
        check("timeout_cmd_ready", 32'(cmd_ready), 32'd1);

        // Reset during ALU_WAIT, then a late done that must be ignored
        step();
        mark();
        send_cmd(OP_ADD, 16'd8);
        rx_q = {8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
        send_bytes();
        step();
        step();
        step();
        check("rstmid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        @(negedge clk);
        check_reset_outputs("rstmid");
        rst = 1'b0;
        step();
        step();
        alu_res_f = 32'hDEAD_BEEF;
        alu_done_f = 1'b1;
        step();
        alu_done_f = 1'b0;
        step();
        step();
        @(negedge clk);
        check("rstmid_late_done_busy", 32'(busy), 32'd0);
        check_tx("rstmid_tx", 0, 32'h0);
        check("rstmid_err", 32'(n_err - b_err), 32'd0);

        // Normal operation resumes
        step();
        alu_en = 1'b1;
        mark();
        send_cmd(OP_ADD, 16'd4);
        rx_q = {8'h44, 8'h33, 8'h22, 8'h11};
        send_bytes();
        wait_idle("post_rst_idle");
        check_tx("post_rst_tx", 4, 32'h1122_3344);
        check("post_rst_starts", 32'(n_start - b_start), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
